// File: rtl/toplevel_soc_pad_in_if.sv
// Avalon-MM slave bus bundle for the input PIO.
// Master drives the strobes, the slave returns registered read data.
interface toplevel_soc_pad_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/toplevel_soc_pad_in.sv
// Input PIO: 2-flop synchroniser, any-edge capture, maskable level irq.
// Optional per-bit debounce with TOPLEVEL_SOC_PAD_IN_DEBOUNCE_EN.
module toplevel_soc_pad_in #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    toplevel_soc_pad_in_if.slave  bus,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);

    logic [WIDTH-1:0] s1, s2, data_q, prev;
    logic [WIDTH-1:0] irq_mask, edge_capture;
    logic [WIDTH-1:0] edge_set, edge_clr;
    logic [1:0]       warm_cnt;
    logic             armed;
    logic             wr_en, rd_en;
    logic [31:0]      rd_mux;
    logic [31:0]      data_ext, mask_ext, cap_ext;
    logic             unused_wdata;

    assign wr_en = bus.chipselect & ~bus.write_n;
    assign rd_en = bus.chipselect & ~bus.read_n;
    assign unused_wdata = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end
    end

`ifdef TOPLEVEL_SOC_PAD_IN_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] db_cnt [WIDTH];

    // a bit is accepted only after it differs for DEBOUNCE_CYCLES clocks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] == data_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    data_q[i] <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end
`else
    localparam int unused_debounce = DEBOUNCE_CYCLES;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) data_q <= '0;
        else          data_q <= s2;
    end
`endif

    // detection arms one cycle after the count saturates so that prev
    // already holds a real sample rather than its reset value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_cnt <= '0;
            armed    <= 1'b0;
            prev     <= '0;
        end else begin
            if (warm_cnt != 2'd3) warm_cnt <= warm_cnt + 2'd1;
            armed <= (warm_cnt == 2'd3);
            prev  <= data_q;
        end
    end

    always_comb begin
        edge_set = '0;
        edge_clr = '0;
        if (armed) edge_set = data_q ^ prev;
        if (wr_en && bus.address == 2'd3) edge_clr = bus.writedata[WIDTH-1:0];
    end

    always_comb begin
        data_ext = '0;
        mask_ext = '0;
        cap_ext  = '0;
        data_ext[WIDTH-1:0] = data_q;
        mask_ext[WIDTH-1:0] = irq_mask;
        cap_ext[WIDTH-1:0]  = edge_capture;
    end

    always_comb begin
        rd_mux = '0;
        unique case (bus.address)
            2'd0: rd_mux = data_ext;
            2'd1: rd_mux = mask_ext;
            2'd2: rd_mux = '0;
            2'd3: rd_mux = cap_ext;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_capture <= '0;
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            if (wr_en && bus.address == 2'd1)
                irq_mask <= bus.writedata[WIDTH-1:0];
            edge_capture <= (edge_capture & ~edge_clr) | edge_set;
            if (rd_en) bus.readdata <= rd_mux;
            irq <= |(edge_capture & irq_mask);
        end
    end

endmodule

// File: tb/tb_toplevel_soc_pad_in.sv
// Directed bench for toplevel_soc_pad_in: register table plus
// hand-timed sequences for latency, irq, W1C races and reset.
module tb_toplevel_soc_pad_in;

`ifdef TOPLEVEL_SOC_PAD_IN_DEBOUNCE_EN
    localparam int DLAT = 2 + 16;
    localparam logic [31:0] RST_CAP = 32'hFF;
`else
    localparam int DLAT = 3;
    localparam logic [31:0] RST_CAP = 32'h0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_port = 8'hFF;
    logic       irq;
    int         checks = 0;
    int         errors = 0;

    toplevel_soc_pad_in_if bus ();

    toplevel_soc_pad_in #(.WIDTH(8), .DEBOUNCE_CYCLES(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        bus.write_n    = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        @(negedge clk);
        idle();
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        bus.address    = a;
        @(negedge clk);
        idle();
        d = bus.readdata;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] held;

        vecs[0] = '{"mask_wr",   1'b1, 2'd1, 32'hFFFF_FFFF};
        vecs[1] = '{"mask_rd",   1'b0, 2'd1, 32'h0000_00FF};
        vecs[2] = '{"data_wr",   1'b1, 2'd0, 32'h1234_5678};
        vecs[3] = '{"data_ro",   1'b0, 2'd0, 32'h0000_00FF};
        vecs[4] = '{"rsv_wr",    1'b1, 2'd2, 32'hFFFF_FFFF};
        vecs[5] = '{"rsv_rd",    1'b0, 2'd2, 32'h0000_0000};
        vecs[6] = '{"mask_wr2",  1'b1, 2'd1, 32'hFFFF_FFA5};
        vecs[7] = '{"mask_rd2",  1'b0, 2'd1, 32'h0000_00A5};
        vecs[8] = '{"mask_wr3",  1'b1, 2'd1, 32'h0000_0000};
        vecs[9] = '{"mask_rd3",  1'b0, 2'd1, 32'h0000_0000};

        idle();
        bus.address   = 2'd0;
        bus.writedata = '0;
        #1;
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        #12 reset_n = 1'b1;

        repeat (5 + DLAT) @(negedge clk);
        rd(2'd3, r);
        check("rst_capture", r, RST_CAP);
        check("rst_irq_idle", {31'h0, irq}, 32'h0);
        rd(2'd0, r);
        check("rst_data", r, 32'hFF);
        wr(2'd3, 32'hFF);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) begin
                wr(vecs[i].addr, vecs[i].data);
            end else begin
                rd(vecs[i].addr, r);
                check(vecs[i].name, r, vecs[i].data);
            end
        end

        @(negedge clk);
        in_port = 8'h00;
        repeat (DLAT + 4) @(negedge clk);
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, r);
        check("cap_cleared", r, 32'h0);
        wr(2'd1, 32'h04);

        // continuous read of DATA while the new value ripples through
        @(negedge clk);
        in_port        = 8'h05;
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        bus.address    = 2'd0;
        for (int k = 1; k <= DLAT + 2; k++) begin
            @(negedge clk);
            if (k == DLAT) check("lat_old", bus.readdata, 32'h00);
            if (k == DLAT + 1) begin
                check("lat_new", bus.readdata, 32'h05);
                check("irq_before", {31'h0, irq}, 32'h0);
            end
            if (k == DLAT + 2) check("irq_rise", {31'h0, irq}, 32'h1);
        end
        idle();
        rd(2'd3, r);
        check("cap_05", r, 32'h05);
        wr(2'd3, 32'h04);
        rd(2'd3, r);
        check("w1c_bit2", r, 32'h01);
        check("irq_fall", {31'h0, irq}, 32'h0);

        wr(2'd3, 32'h01);
        rd(2'd3, r);
        check("w1c_bit0", r, 32'h00);
        @(negedge clk);
        in_port = 8'h04;
        repeat (DLAT) @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = 2'd3;
        bus.writedata  = 32'h01;
        @(negedge clk);
        idle();
        rd(2'd3, r);
        check("set_wins", r, 32'h01);

        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        bus.write_n    = 1'b0;
        bus.address    = 2'd1;
        bus.writedata  = 32'h3C;
        @(negedge clk);
        idle();
        check("rw_old", bus.readdata, 32'h04);
        rd(2'd1, r);
        check("rw_new", r, 32'h3C);

        rd(2'd0, r);
        check("data_04", r, 32'h04);
        held = r;
        @(negedge clk);
        bus.read_n  = 1'b0;
        bus.write_n = 1'b0;
        bus.address = 2'd1;
        bus.writedata = 32'h00;
        @(negedge clk);
        idle();
        check("cs_low_hold", bus.readdata, held);
        rd(2'd1, r);
        check("cs_low_nowr", r, 32'h3C);

        wr(2'd1, 32'hFF);
        @(negedge clk);
        in_port = 8'h00;
        repeat (DLAT + 3) @(negedge clk);
        check("irq_pre_rst", {31'h0, irq}, 32'h1);
        rd(2'd1, r);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_rd", bus.readdata, 32'h0);
        check("mid_rst_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5 + DLAT) @(negedge clk);
        rd(2'd1, r);
        check("mid_rst_mask", r, 32'h0);
        rd(2'd3, r);
        check("mid_rst_cap", r, 32'h0);

`ifdef TOPLEVEL_SOC_PAD_IN_DEBOUNCE_EN
        @(negedge clk);
        in_port = 8'h08;
        repeat (10) @(negedge clk);
        in_port = 8'h00;
        repeat (30) @(negedge clk);
        rd(2'd0, r);
        check("db_pulse_data", r, 32'h00);
        rd(2'd3, r);
        check("db_pulse_cap", r, 32'h00);
        @(negedge clk);
        in_port = 8'h08;
        repeat (DLAT - 1) @(negedge clk);
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        bus.address    = 2'd0;
        @(negedge clk);
        check("db_hold_early", bus.readdata, 32'h00);
        @(negedge clk);
        idle();
        check("db_hold_data", bus.readdata, 32'h08);
        repeat (4) @(negedge clk);
        rd(2'd3, r);
        check("db_hold_cap", r, 32'h08);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
